// File: rtl/vector_pkg.sv
// Shared types and default dimensions for the vector datapath write-back path.
package vector_pkg;

    localparam int unsigned NUM_ITEMS = 20;
    localparam int unsigned ITEM_LEN  = 32;
    localparam int unsigned ADDR_LEN  = 6;

    typedef logic [ITEM_LEN-1:0] item_t;
    typedef item_t [NUM_ITEMS-1:0] vector_t;

    typedef enum logic {
        OP_SCALAR = 1'b0,
        OP_VECTOR = 1'b1
    } op_type_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WRITE,
        WR_DONE
    } wr_state_e;

    // Index must be able to hold the item count itself, hence n+1.
    function automatic int unsigned index_width(int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/write_module_if.sv
// Request/memory-write bundle of write_module; lane_mask exists only with WRITE_MODULE_MASK_EN.
interface write_module_if
    import vector_pkg::*;
#(
    parameter int unsigned I = NUM_ITEMS,
    parameter int unsigned L = ITEM_LEN,
    parameter int unsigned A = ADDR_LEN
);
    logic                  start;
    logic                  op_type;
    logic [A-1:0]          base_address;
    logic [L-1:0]          scalar_data;
    logic [I-1:0][L-1:0]   vector_data;
`ifdef WRITE_MODULE_MASK_EN
    logic [I-1:0]          lane_mask;
`endif
    logic [A-1:0]          write_address;
    logic [L-1:0]          write_data;
    logic                  write_enable;
    logic                  busy;
    logic                  finished;

    modport master (
`ifdef WRITE_MODULE_MASK_EN
        output lane_mask,
`endif
        output start, op_type, base_address, scalar_data, vector_data,
        input  write_address, write_data, write_enable, busy, finished
    );

    modport slave (
`ifdef WRITE_MODULE_MASK_EN
        input  lane_mask,
`endif
        input  start, op_type, base_address, scalar_data, vector_data,
        output write_address, write_data, write_enable, busy, finished
    );

endinterface

// File: rtl/write_counter.sv
// Item index register with synchronous clear/enable and a last-item flag.
module write_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] count,
    output logic [W-1:0] index,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index <= '0;
        end else if (clear) begin
            index <= '0;
        end else if (en) begin
            index <= index + 1'b1;
        end
    end

    assign tc = (index == count - 1'b1);

endmodule

// File: rtl/write_module.sv
// Write-back engine: streams a latched scalar or vector into data memory, one item per cycle.
// Optional per-lane write masking is enabled with WRITE_MODULE_MASK_EN.
module write_module
    import vector_pkg::*;
#(
    parameter int unsigned I = NUM_ITEMS,
    parameter int unsigned L = ITEM_LEN,
    parameter int unsigned A = ADDR_LEN
) (
    input logic           clk,
    input logic           rst,
    write_module_if.slave bus
);

    localparam int unsigned IW = index_width(I);

    wr_state_e           state;
    logic [IW-1:0]       count_q;
    logic [IW-1:0]       index;
    logic [IW-1:0]       index_nxt;
    logic                tc;
    logic                accept;
    logic                in_write;
    logic [A-1:0]        base_q;
    logic [I-1:0][L-1:0] shadow_q;
    logic                is_vector;
`ifdef WRITE_MODULE_MASK_EN
    logic [I-1:0]        mask_q;
`endif

    logic [A-1:0]        addr_q;
    logic [L-1:0]        data_q;
    logic                we_q;
    logic                busy_q;
    logic                fin_q;

    assign is_vector = (op_type_e'(bus.op_type) == OP_VECTOR);
    assign accept    = (state == WR_IDLE) && bus.start;
    assign in_write  = (state == WR_WRITE);
    assign index_nxt = index + 1'b1;

    write_counter #(
        .W(IW)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .clear(accept),
        .en   (in_write),
        .count(count_q),
        .index(index),
        .tc   (tc)
    );

    // Outputs are registered one cycle ahead: each edge loads the item for the coming cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WR_IDLE;
            count_q  <= '0;
            base_q   <= '0;
            shadow_q <= '0;
`ifdef WRITE_MODULE_MASK_EN
            mask_q   <= '0;
`endif
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            unique case (state)
                WR_IDLE: begin
                    fin_q <= 1'b0;
                    if (bus.start) begin
                        base_q <= bus.base_address;
                        if (is_vector) begin
                            shadow_q <= bus.vector_data;
                            count_q  <= IW'(I);
                            data_q   <= bus.vector_data[0];
                        end else begin
                            shadow_q    <= '0;
                            shadow_q[0] <= bus.scalar_data;
                            count_q     <= IW'(1);
                            data_q      <= bus.scalar_data;
                        end
`ifdef WRITE_MODULE_MASK_EN
                        if (is_vector) begin
                            mask_q <= bus.lane_mask;
                        end else begin
                            mask_q    <= '0;
                            mask_q[0] <= bus.lane_mask[0];
                        end
                        we_q <= bus.lane_mask[0];
`else
                        we_q <= 1'b1;
`endif
                        addr_q <= bus.base_address;
                        busy_q <= 1'b1;
                        state  <= WR_WRITE;
                    end
                end
                WR_WRITE: begin
                    if (tc) begin
                        we_q   <= 1'b0;
                        busy_q <= 1'b0;
                        fin_q  <= 1'b1;
                        state  <= WR_DONE;
                    end else begin
                        addr_q <= base_q + A'(index_nxt);
                        data_q <= shadow_q[index_nxt];
`ifdef WRITE_MODULE_MASK_EN
                        we_q   <= mask_q[index_nxt];
`else
                        we_q   <= 1'b1;
`endif
                    end
                end
                WR_DONE: begin
                    fin_q <= 1'b0;
                    state <= WR_IDLE;
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

    assign bus.write_address = addr_q;
    assign bus.write_data    = data_q;
    assign bus.write_enable  = we_q;
    assign bus.busy          = busy_q;
    assign bus.finished      = fin_q;

endmodule
